serial_subtractor: RTL and testbench

Bit-serial unsigned subtractor. It computes diff = a − b over WIDTH bits, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's full-adder datapath. It sits behind a start/done handshake so a controller can issue operands and collect the result and final borrow.

---
 rtl/serial_subtractor.sv | 97 +++++++++
 tb/tb_serial_subtractor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a registered
// borrow compute diff = a - b over WIDTH clocks, LSB first, behind start/done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] pr;
  logic [WIDTH-1:0] pr_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;

  always_comb begin
    ai      = sa[0];
    bi      = sb[0];
    d       = ai ^ bi ^ br;
    br_next = (~ai & bi) | (~(ai ^ bi) & br);
    // Shift then overwrite the MSB so WIDTH=1 needs no zero-width slice.
    pr_next            = pr >> 1;
    pr_next[WIDTH-1]   = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      pr    <= '0;
      cnt   <= '0;
      br    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            pr    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          pr  <= pr_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff  <= pr_next;
            bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH 8, 1 and 2,
// checked against plain modular arithmetic and cycle-count expectations.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;
  logic       start2, busy2, done2, bout2;
  logic [1:0] a2, b2, diff2;

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2));

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : (w == 1) ? busy1 : busy2;
  endfunction
  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : (w == 1) ? done1 : done2;
  endfunction
  function automatic logic [7:0] cur_diff(input int w);
    return (w == 8) ? diff8 : (w == 1) ? {7'd0, diff1} : {6'd0, diff2};
  endfunction
  function automatic logic cur_bout(input int w);
    return (w == 8) ? bout8 : (w == 1) ? bout1 : bout2;
  endfunction

  // Reference: (a - b) mod 2^w and unsigned a < b.
  function automatic logic [7:0] ref_diff(input int w, input logic [7:0] av, input logic [7:0] bv);
    int unsigned m;
    m = (1 << w) - 1;
    return 8'((int'(av & 8'(m)) - int'(bv & 8'(m))) & m);
  endfunction
  function automatic logic ref_bout(input int w, input logic [7:0] av, input logic [7:0] bv);
    int unsigned m;
    m = (1 << w) - 1;
    return (av & 8'(m)) < (bv & 8'(m));
  endfunction

  // Issues one operation (called #1 after an edge, DUT idle) and returns the
  // observed result, latency in edges, busy samples and done one cycle later.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] d, output logic bo, output int lat,
                        output int bcyc, output logic dlate);
    case (w)
      8:       begin start8 = 1'b1; a8 = av;      b8 = bv;      end
      1:       begin start1 = 1'b1; a1 = av[0];   b1 = bv[0];   end
      default: begin start2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; end
    endcase
    @(posedge clk); #1;
    start8 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    bcyc = cur_busy(w) ? 1 : 0;
    lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (cur_done(w)) begin
        lat = k;
        break;
      end
      if (cur_busy(w)) bcyc++;
    end
    d  = cur_diff(w);
    bo = cur_bout(w);
    @(posedge clk); #1;
    dlate = cur_done(w);
  endtask

  task automatic check_op(input int w, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] d;
    logic       bo, dlate;
    int         lat, bcyc;
    run_op(w, av, bv, d, bo, lat, bcyc, dlate);
    tests++;
    if (d !== ref_diff(w, av, bv)) begin
      fails++;
      $display("FAIL diff w=%0d a=%h b=%h got=%h exp=%h", w, av, bv, d, ref_diff(w, av, bv));
    end
    tests++;
    if (bo !== ref_bout(w, av, bv)) begin
      fails++;
      $display("FAIL bout w=%0d a=%h b=%h got=%b exp=%b", w, av, bv, bo, ref_bout(w, av, bv));
    end
    tests++;
    if (lat != w) begin
      fails++;
      $display("FAIL latency w=%0d got=%0d exp=%0d", w, lat, w);
    end
    tests++;
    if (bcyc != w) begin
      fails++;
      $display("FAIL busy_cycles w=%0d got=%0d exp=%0d", w, bcyc, w);
    end
    tests++;
    if (dlate !== 1'b0) begin
      fails++;
      $display("FAIL done_width w=%0d done still %b one cycle later", w, dlate);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy8, done8, diff8, bout8, busy1, done1, diff1, bout1, busy2, done2, diff2, bout2} !== '0) begin
      fails++;
      $display("FAIL reset_state busy8=%b done8=%b diff8=%h bout8=%b busy1=%b done1=%b busy2=%b done2=%b",
               busy8, done8, diff8, bout8, busy1, done1, busy2, done2);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op(8, 8'h05, 8'h03);
    check_op(8, 8'h03, 8'h05);
    check_op(8, 8'h00, 8'h01);
    check_op(8, 8'hFF, 8'hFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      check_op(8, 8'($urandom), 8'($urandom));
  endtask

  task automatic test_small_widths();
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        check_op(1, 8'(av), 8'(bv));
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        check_op(2, 8'(av), 8'(bv));
  endtask

  task automatic test_ignore_restart();
    int         ndone = 0;
    int         done_at = -1;
    logic [7:0] d = 8'h00;
    logic       bo = 1'b0;
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
    @(posedge clk); #1;                        // E0
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(posedge clk);                 // E1, E2
    #1;
    start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    @(posedge clk); #1;                        // E3 sees start in SHIFT
    start8 = 1'b0;
    for (int k = 4; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        ndone++;
        if (done_at < 0) begin
          done_at = k; d = diff8; bo = bout8;
        end
      end
    end
    tests++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL restart_done_count got=%0d exp=1", ndone);
    end
    tests++;
    if (done_at != 8) begin
      fails++;
      $display("FAIL restart_done_edge got=E%0d exp=E8", done_at);
    end
    tests++;
    if (d !== 8'h0F || bo !== 1'b0) begin
      fails++;
      $display("FAIL restart_result got diff=%h bout=%b exp diff=0f bout=0", d, bo);
    end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int bad_diff = 0;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
    for (int k = 0; k <= 29; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        q.push_back(k);
        if (diff8 !== 8'h7F || bout8 !== 1'b0) bad_diff++;
      end
    end
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    tests++;
    if (q.size() != 3 || q[0] != 8 || q[1] != 18 || q[2] != 28) begin
      fails++;
      $display("FAIL b2b_done_edges got count=%0d first=%0d exp E8,E18,E28", q.size(),
               (q.size() > 0) ? q[0] : -1);
    end
    tests++;
    if (bad_diff != 0) begin
      fails++;
      $display("FAIL b2b_result got %0d bad results exp 0 (diff=7f bout=0)", bad_diff);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int seen = 0;
    start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(posedge clk); #1;                        // E0
    start8 = 1'b0;
    repeat (4) @(posedge clk);                 // E1..E4
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || bout8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs got busy=%b done=%b diff=%h bout=%b exp all 0",
               busy8, done8, diff8, bout8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8 || busy8) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done got %0d active cycles exp 0", ndone);
    end
    check_op(8, 8'h0A, 8'h0A);

    // Reset arriving while done is high must clear it at once.
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h22;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        seen = 1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (seen != 1 || done8 !== 1'b0 || diff8 !== 8'h00) begin
      fails++;
      $display("FAIL reset_on_done got seen=%0d done=%b diff=%h exp seen=1 done=0 diff=00",
               seen, done8, diff8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_small_widths();
    test_ignore_restart();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
